// File: rtl/operand_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : operand_fetch_if
//  Description : Bundle of the decode-side, register-file, writeback, flush,
//                execute-side and scoreboard signals of the operand fetch
//                stage.
//                master : the surrounding pipeline (drives the stage inputs)
//                slave  : the operand_fetch stage itself
//  Signals     : in_valid/in_ready/in_rn/in_rm/in_rd/in_we   decode side
//                rf_addr1/rf_addr2/rf_data1/rf_data2         register file
//                wb_valid/wb_addr/wb_data                    writeback
//                flush                                       pipeline flush
//                out_valid/out_ready/out_op1/out_op2/
//                out_rd/out_we                               execute side
//                busy                                        pending writes
//  Revision    : 1.0  initial release
// ============================================================================
interface operand_fetch_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_rn;
    logic [3:0]  in_rm;
    logic [3:0]  in_rd;
    logic        in_we;
    logic [3:0]  rf_addr1;
    logic [3:0]  rf_addr2;
    logic [31:0] rf_data1;
    logic [31:0] rf_data2;
    logic        wb_valid;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_op1;
    logic [31:0] out_op2;
    logic [3:0]  out_rd;
    logic        out_we;
    logic [15:0] busy;

    modport master (
        output in_valid, in_rn, in_rm, in_rd, in_we,
        output rf_data1, rf_data2,
        output wb_valid, wb_addr, wb_data,
        output flush, out_ready,
        input  in_ready, rf_addr1, rf_addr2,
        input  out_valid, out_op1, out_op2, out_rd, out_we, busy
    );

    modport slave (
        input  in_valid, in_rn, in_rm, in_rd, in_we,
        input  rf_data1, rf_data2,
        input  wb_valid, wb_addr, wb_data,
        input  flush, out_ready,
        output in_ready, rf_addr1, rf_addr2,
        output out_valid, out_op1, out_op2, out_rd, out_we, busy
    );
endinterface
`default_nettype wire

// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : operand_fetch
//  Description : Operand fetch pipeline stage. Reads two source registers,
//                checks a 16-entry pending-write scoreboard for RAW hazards,
//                and registers an operand bundle for the execute stage with
//                a valid/ready handshake (1-cycle latency, no bubble on
//                back-to-back transfers).
//  Ports       : clk  - rising-edge clock
//                rst  - asynchronous active-low reset
//                bus  - operand_fetch_if.slave (decode, register file,
//                       writeback, flush, execute and scoreboard signals)
//  Options     : OPFETCH_BYPASS_EN - when defined, a writeback in the same
//                cycle resolves the hazard on a matching source register
//                and supplies that operand directly from wb_data.
//  Revision    : 1.0  initial release
// ============================================================================
module operand_fetch (
    input  wire logic        clk,
    input  wire logic        rst,
    operand_fetch_if.slave   bus
);

    logic [15:0] r_busy;
    logic        r_out_valid;
    logic [31:0] r_out_op1;
    logic [31:0] r_out_op2;
    logic [3:0]  r_out_rd;
    logic        r_out_we;

    logic        w_byp1;
    logic        w_byp2;
    logic        w_haz;
    logic        w_ready;
    logic        w_xfer;
    logic [31:0] w_op1;
    logic [31:0] w_op2;
    logic [15:0] w_set_mask;
    logic [15:0] w_clr_mask;

    // Register-file addresses are plain copies of the source indices so the
    // read data arrives in the same cycle as the instruction.
    assign bus.rf_addr1 = bus.in_rn;
    assign bus.rf_addr2 = bus.in_rm;

`ifdef OPFETCH_BYPASS_EN
    // A retiring write to a source register resolves its hazard this cycle.
    assign w_byp1 = bus.wb_valid && (bus.wb_addr == bus.in_rn);
    assign w_byp2 = bus.wb_valid && (bus.wb_addr == bus.in_rm);
`else
    // No forwarding: a busy source waits until its bit has been cleared,
    // by which time the register file holds the written value.
    assign w_byp1 = 1'b0;
    assign w_byp2 = 1'b0;
`endif

    // Hazard uses the scoreboard as it stands before this edge, so an
    // instruction whose rd equals one of its sources never stalls itself.
    assign w_haz = (r_busy[bus.in_rn] && !w_byp1) ||
                   (r_busy[bus.in_rm] && !w_byp2);

    assign w_ready = rst && (!r_out_valid || bus.out_ready) && !w_haz && !bus.flush;
    assign w_xfer  = bus.in_valid && w_ready;

    assign w_op1 = w_byp1 ? bus.wb_data : bus.rf_data1;
    assign w_op2 = w_byp2 ? bus.wb_data : bus.rf_data2;

    // Clear is applied before set so a same-index set wins.
    assign w_set_mask = (w_xfer && bus.in_we) ? (16'd1 << bus.in_rd)   : 16'd0;
    assign w_clr_mask = bus.wb_valid          ? (16'd1 << bus.wb_addr) : 16'd0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy      <= 16'h0000;
            r_out_valid <= 1'b0;
            r_out_op1   <= 32'd0;
            r_out_op2   <= 32'd0;
            r_out_rd    <= 4'd0;
            r_out_we    <= 1'b0;
        end else if (bus.flush) begin
            // Flush discards the held bundle and all pending writes; the
            // bundle data registers keep their contents, only valid drops.
            r_busy      <= 16'h0000;
            r_out_valid <= 1'b0;
        end else begin
            r_busy <= (r_busy & ~w_clr_mask) | w_set_mask;
            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_out_op1   <= w_op1;
                r_out_op2   <= w_op2;
                r_out_rd    <= bus.in_rd;
                r_out_we    <= bus.in_we;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_op1   = r_out_op1;
    assign bus.out_op2   = r_out_op2;
    assign bus.out_rd    = r_out_rd;
    assign bus.out_we    = r_out_we;
    assign bus.busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_operand_fetch
//  Description : Self-checking bench for operand_fetch. Directed scenarios
//                with literal expectations, then randomized traffic checked
//                every cycle against a behavioural model of the stage.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_operand_fetch;

`ifdef OPFETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    operand_fetch_if bus ();

    operand_fetch dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit          m_busy [16];
    bit          m_valid;
    logic [31:0] m_op1;
    logic [31:0] m_op2;
    logic [3:0]  m_rd;
    bit          m_we;

    task automatic model_clear();
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_valid = 1'b0;
        m_op1   = 32'd0;
        m_op2   = 32'd0;
        m_rd    = 4'd0;
        m_we    = 1'b0;
    endtask

    function automatic bit src_stalls(input logic [3:0] idx);
        bit fwd;
        fwd = BYP && bus.wb_valid && (bus.wb_addr == idx);
        return m_busy[idx] && !fwd;
    endfunction

    function automatic bit exp_ready();
        if (!rst)                        return 1'b0;
        if (bus.flush)                   return 1'b0;
        if (m_valid && !bus.out_ready)   return 1'b0;
        if (src_stalls(bus.in_rn))       return 1'b0;
        if (src_stalls(bus.in_rm))       return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [15:0] busy_vec();
        logic [15:0] v;
        for (int i = 0; i < 16; i++) v[i] = m_busy[i];
        return v;
    endfunction

    always @(negedge rst) model_clear();

    always @(posedge clk) begin
        bit take;
        if (!rst) begin
            model_clear();
        end else if (bus.flush) begin
            m_valid = 1'b0;
            foreach (m_busy[i]) m_busy[i] = 1'b0;
        end else begin
            take = bus.in_valid && exp_ready();
            if (take) begin
                m_valid = 1'b1;
                m_op1 = (BYP && bus.wb_valid && bus.wb_addr == bus.in_rn) ? bus.wb_data : bus.rf_data1;
                m_op2 = (BYP && bus.wb_valid && bus.wb_addr == bus.in_rm) ? bus.wb_data : bus.rf_data2;
                m_rd  = bus.in_rd;
                m_we  = bus.in_we;
            end else if (bus.out_ready) begin
                m_valid = 1'b0;
            end
            if (bus.wb_valid)        m_busy[bus.wb_addr] = 1'b0;
            if (take && bus.in_we)   m_busy[bus.in_rd]   = 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        check("in_ready",  {31'd0, bus.in_ready},  {31'd0, exp_ready()});
        check("rf_addr1",  {28'd0, bus.rf_addr1},  {28'd0, bus.in_rn});
        check("rf_addr2",  {28'd0, bus.rf_addr2},  {28'd0, bus.in_rm});
        check("out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
        check("busy",      {16'd0, bus.busy},      {16'd0, busy_vec()});
        check("out_op1",   bus.out_op1,            m_op1);
        check("out_op2",   bus.out_op2,            m_op2);
        check("out_rd",    {28'd0, bus.out_rd},    {28'd0, m_rd});
        check("out_we",    {31'd0, bus.out_we},    {31'd0, m_we});
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_in(input bit v, input int rn, input int rm, input int rd, input bit we);
        bus.in_valid = v;
        bus.in_rn    = 4'(rn);
        bus.in_rm    = 4'(rm);
        bus.in_rd    = 4'(rd);
        bus.in_we    = we;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0);
        bus.rf_data1  = 32'd0;
        bus.rf_data2  = 32'd0;
        bus.wb_valid  = 1'b0;
        bus.wb_addr   = 4'd0;
        bus.wb_data   = 32'd0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        #1 rst = 1'b0;
        #1;
        check("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("reset busy",      {16'd0, bus.busy},      32'd0);
        check("reset in_ready",  {31'd0, bus.in_ready},  32'd0);
        tick();
        tick();

        // First transfer on the first edge with reset released.
        rst = 1'b1;
        set_in(1, 1, 2, 3, 1);
        bus.rf_data1 = 32'd5;
        bus.rf_data2 = 32'd7;
        #1 check("first in_ready", {31'd0, bus.in_ready}, 32'd1);
        tick();
        check("first out_valid", {31'd0, bus.out_valid}, 32'd1);
        check("first op1",       bus.out_op1,            32'd5);
        check("first op2",       bus.out_op2,            32'd7);
        check("first rd",        {28'd0, bus.out_rd},    32'd3);
        check("first busy",      {16'd0, bus.busy},      32'h0008);

        // Hazard on r3, resolved by writeback.
        set_in(1, 3, 0, 0, 0);
        bus.out_ready = 1'b1;
        bus.rf_data1  = 32'h11;
        bus.rf_data2  = 32'h0;
        #1 check("hazard stall", {31'd0, bus.in_ready}, 32'd0);
        tick();
        bus.wb_valid = 1'b1;
        bus.wb_addr  = 4'd3;
        bus.wb_data  = 32'hAA;
        #1;
        if (BYP) begin
            check("bypass ready", {31'd0, bus.in_ready}, 32'd1);
            tick();
            bus.in_valid = 1'b0;
            bus.wb_valid = 1'b0;
            check("bypass op1", bus.out_op1, 32'hAA);
            held = 32'hAA;
        end else begin
            check("no-bypass stall on wb", {31'd0, bus.in_ready}, 32'd0);
            tick();
            bus.wb_valid = 1'b0;
            #1 check("no-bypass ready", {31'd0, bus.in_ready}, 32'd1);
            tick();
            bus.in_valid = 1'b0;
            check("no-bypass op1", bus.out_op1, 32'h11);
            held = 32'h11;
        end
        check("hazard out_valid", {31'd0, bus.out_valid}, 32'd1);
        check("hazard busy",      {16'd0, bus.busy},      32'd0);

        // Backpressure: bundle holds for 3 cycles, then replaced with no bubble.
        bus.out_ready = 1'b0;
        set_in(1, 5, 6, 7, 1);
        bus.rf_data1 = 32'h55;
        bus.rf_data2 = 32'h66;
        for (int k = 0; k < 3; k++) begin
            #1 check("stall in_ready", {31'd0, bus.in_ready}, 32'd0);
            tick();
            check("hold op1",   bus.out_op1,            held);
            check("hold valid", {31'd0, bus.out_valid}, 32'd1);
        end
        bus.out_ready = 1'b1;
        #1 check("release in_ready", {31'd0, bus.in_ready}, 32'd1);
        tick();
        bus.in_valid = 1'b0;
        check("replace valid", {31'd0, bus.out_valid}, 32'd1);
        check("replace op1",   bus.out_op1,            32'h55);
        check("replace op2",   bus.out_op2,            32'h66);
        check("replace rd",    {28'd0, bus.out_rd},    32'd7);
        check("replace busy",  {16'd0, bus.busy},      32'h0080);

        // Same-cycle set and clear of r4: set wins.
        set_in(1, 0, 0, 4, 1);
        bus.wb_valid = 1'b1;
        bus.wb_addr  = 4'd4;
        bus.wb_data  = 32'd0;
        #1 check("set/clr ready", {31'd0, bus.in_ready}, 32'd1);
        tick();
        bus.wb_valid = 1'b0;
        check("set wins busy", {16'd0, bus.busy}, 32'h0090);

        // Build busy=0x00F0 then flush.
        bus.in_rd = 4'd5;
        tick();
        bus.in_rd = 4'd6;
        tick();
        bus.out_ready = 1'b0;
        check("pre-flush busy",  {16'd0, bus.busy},      32'h00F0);
        check("pre-flush valid", {31'd0, bus.out_valid}, 32'd1);
        bus.flush = 1'b1;
        #1 check("flush in_ready", {31'd0, bus.in_ready}, 32'd0);
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        check("flush busy",  {16'd0, bus.busy},      32'd0);
        check("flush valid", {31'd0, bus.out_valid}, 32'd0);

        // Asynchronous reset between edges with a bundle held.
        set_in(1, 1, 2, 9, 1);
        tick();
        bus.in_valid = 1'b0;
        check("pre-reset valid", {31'd0, bus.out_valid}, 32'd1);
        check("pre-reset busy",  {16'd0, bus.busy},      32'h0200);
        #1 rst = 1'b0;
        #1;
        check("async valid",    {31'd0, bus.out_valid}, 32'd0);
        check("async busy",     {16'd0, bus.busy},      32'd0);
        check("async op1",      bus.out_op1,            32'd0);
        check("async rd",       {28'd0, bus.out_rd},    32'd0);
        check("async in_ready", {31'd0, bus.in_ready},  32'd0);
        tick();
        rst = 1'b1;

        // Randomized traffic checked by the compare process.
        for (int n = 0; n < 3000; n++) begin
            tick();
            if (!rst)                            rst = 1'b1;
            else if ($urandom_range(0, 299) == 0) rst = 1'b0;
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_rn     = 4'($urandom_range(0, 15));
            bus.in_rm     = ($urandom_range(0, 7) == 0) ? bus.in_rn : 4'($urandom_range(0, 15));
            bus.in_rd     = 4'($urandom_range(0, 15));
            bus.in_we     = ($urandom_range(0, 2) != 0);
            bus.rf_data1  = $urandom;
            bus.rf_data2  = $urandom;
            bus.wb_valid  = ($urandom_range(0, 4) < 2);
            bus.wb_addr   = 4'($urandom_range(0, 15));
            bus.wb_data   = $urandom;
            bus.flush     = ($urandom_range(0, 49) == 0);
            bus.out_ready = ($urandom_range(0, 9) < 7);
        end
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset. Ports: clk input 1, rising-edge clock; rst input 1, asynchronous active-low reset.
REQ-002 in_valid  input  1  decoded instruction present.
REQ-003 in_ready  output  1  stage accepts this cycle.
REQ-004 in_rn, in_rm, in_rd  input  4 each  source 1, source 2, destination register index.
REQ-005 in_we  input  1  instruction will write in_rd.
REQ-006 rf_addr1, rf_addr2  output  4 each  register-file read addresses; combinational copies of in_rn, in_rm.
REQ-007 rf_data1, rf_data2  input  32 each  register-file read data, same cycle.
REQ-008 wb_valid  input  1  writeback retiring a write this cycle.
REQ-009 wb_addr  input  4  register being written back.
REQ-010 wb_data  input  32  data being written back.
REQ-011 flush  input  1  synchronous pipeline flush.
REQ-012 out_valid  output  1  operand bundle valid.
REQ-013 out_ready  input  1  execute stage consumes the bundle.
REQ-014 out_op1, out_op2  output  32 each  registered operands.
REQ-015 out_rd  output  4  registered destination index.
REQ-016 out_we  output  1  registered write flag.
REQ-017 busy  output  16  scoreboard; bit n set means register n has a pending write.

Function
REQ-018 A transfer SHALL occur on a rising edge when in_valid && in_ready; out_valid SHALL rise the next cycle (1-cycle latency).
REQ-019 A hazard exists when busy[in_rn] or busy[in_rm] is set and that bit is not resolved by bypass (REQ-027).
REQ-020 in_ready SHALL be (!out_valid || out_ready) && !hazard && !flush.
REQ-021 While out_valid && !out_ready, all out_* SHALL hold stable.
REQ-022 When out_valid && out_ready and no new transfer occurs, out_valid SHALL fall the next cycle. When both occur in the same cycle, the bundle SHALL be replaced with no bubble.
REQ-023 On a transfer with in_we=1, busy[in_rd] SHALL be set on that edge.
REQ-024 On wb_valid, busy[wb_addr] SHALL be cleared. When a clear and a set target the same index in the same cycle, the set wins. A clear of a non-busy bit has no effect.
REQ-025 The hazard check SHALL use busy before this cycle's update, so in_rd equal to in_rn or in_rm does not self-stall.
REQ-026 rn == rm SHALL be legal; both operands SHALL see identical data and hazard status.
REQ-027 Bypass: when wb_valid and wb_addr matches in_rn (or in_rm), the matching operand SHALL capture wb_data and that register's hazard SHALL be resolved (see REQ-035).
REQ-028 flush SHALL take priority over all other events: on that edge, out_valid SHALL be cleared, busy SHALL be cleared to 0, and no transfer SHALL occur.
REQ-029 Register index 15 SHALL receive no special treatment.

Reset
REQ-030 Asserting rst low SHALL immediately force out_valid=0, busy=16'h0000, out_op1=out_op2=0, out_rd=0, out_we=0, independent of clk.
REQ-031 A reset asserted mid-operation SHALL discard the held bundle and all pending-write state.
REQ-032 in_ready SHALL be 0 while rst is low.
REQ-033 The first transfer after reset SHALL be possible on the first rising edge with rst high.

Configuration
REQ-034 Macro OPFETCH_BYPASS_EN SHALL control the writeback bypass.
REQ-035 With OPFETCH_BYPASS_EN defined: REQ-027 applies.
REQ-036 Without OPFETCH_BYPASS_EN: no bypass path exists. A busy source register SHALL stall until the cycle after its busy bit clears, and operands SHALL come only from rf_data1 and rf_data2.

Verification
REQ-037 Reset then in_valid, rn=1, rm=2, rd=3, we=1, rf_data1=5, rf_data2=7 -> next cycle out_valid=1, out_op1=5, out_op2=7, out_rd=3, busy=16'h0008.
REQ-038 busy[3] set, issue rn=3 -> in_ready=0. Then wb_valid=1, wb_addr=3, wb_data=32'hAA -> with bypass: accepted that cycle, out_op1=32'hAA. Without bypass: accepted the next cycle from rf_data1.
REQ-039 out_ready=0 with a bundle held, in_valid=1 -> in_ready=0 and out_* unchanged for 3 cycles. Then raise out_ready -> new bundle replaces the old one with no bubble.
REQ-040 Same cycle: transfer with rd=4, we=1 and wb_valid with wb_addr=4 -> busy[4]=1 afterwards.
REQ-041 busy=16'h00F0, out_valid=1, pulse flush -> next cycle busy=0, out_valid=0, and in_ready=0 during the flush cycle.
REQ-042 Assert rst low between clock edges while out_valid=1 -> out_valid=0 and busy=0 immediately, before the next edge.
